// File: rtl/frodo_sampler.sv
`timescale 1ns/1ps
// frodo_sampler: FrodoKEM error-sample generator.
// Maps each 16-bit random word through the selected CDF inversion table to a
// 5-bit sign-magnitude sample, packs S samples into one column word, and hands
// the column to the matrix multiplier through a collect/output double buffer.
module frodo_sampler #(
   parameter int S    = 8,
   parameter int PSET = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [15:0]      rnd,
   input  logic             rndValid,
   output logic             rndReady,
   output logic [5*S-1:0]   sCol,
   output logic             sColValid,
   input  logic             sColReady
);

   localparam int CW   = $clog2(S + 1);
   localparam int L    = (PSET == 2) ? 7 : ((PSET == 1) ? 11 : 13);
   localparam int NCMP = L - 1;

   // CDF threshold j of the selected parameter set. PSET values other than
   // 1 and 2 fall back to the FrodoKEM-640 table.
   function automatic logic [14:0] cdf_entry(input int j);
      logic [14:0] v;
      v = 15'd32767;
      if (PSET == 2) begin
         case (j)
            0:       v = 15'd9142;
            1:       v = 15'd23462;
            2:       v = 15'd30338;
            3:       v = 15'd32361;
            4:       v = 15'd32725;
            5:       v = 15'd32765;
            default: v = 15'd32767;
         endcase
      end else if (PSET == 1) begin
         case (j)
            0:       v = 15'd5638;
            1:       v = 15'd15915;
            2:       v = 15'd23689;
            3:       v = 15'd28571;
            4:       v = 15'd31116;
            5:       v = 15'd32217;
            6:       v = 15'd32613;
            7:       v = 15'd32731;
            8:       v = 15'd32760;
            9:       v = 15'd32766;
            default: v = 15'd32767;
         endcase
      end else begin
         case (j)
            0:       v = 15'd4643;
            1:       v = 15'd13363;
            2:       v = 15'd20579;
            3:       v = 15'd25843;
            4:       v = 15'd29227;
            5:       v = 15'd31145;
            6:       v = 15'd32103;
            7:       v = 15'd32525;
            8:       v = 15'd32689;
            9:       v = 15'd32745;
            10:      v = 15'd32762;
            11:      v = 15'd32766;
            default: v = 15'd32767;
         endcase
      end
      return v;
   endfunction

   logic [14:0]     t;
   logic [NCMP-1:0] above;
   logic [3:0]      mag;
   logic [4:0]      sample;
   logic [CW-1:0]   cnt;
   logic [5*S-1:0]  collect;
   logic            accept;
   logic            group_full;
   logic            transfer;
   logic            pop;

   assign t = rnd[15:1];

   // Every threshold is compared on every word so the mapping time never
   // depends on the random value.
   for (genvar j = 0; j < NCMP; j++) begin : g_cmp
      localparam logic [14:0] THR = cdf_entry(j);
      assign above[j] = (THR < t);
   end

   // Magnitude is the number of thresholds strictly below t.
   always_comb begin
      mag = 4'd0;
      for (int j = 0; j < NCMP; j++) begin
         mag = mag + {3'd0, above[j]};
      end
   end

   assign sample     = {mag, rnd[0]};
   assign group_full = (cnt == CW'(S));
   assign rndReady   = !group_full;
   assign accept     = rndValid && rndReady;
   assign pop        = sColValid && sColReady;
   assign transfer   = group_full && (!sColValid || sColReady);

   // Fill counter: advances per accepted word, rewinds when the group moves out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (transfer) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Collect register: the accepted sample lands in the slot selected by cnt,
   // so the first word of a group occupies the lowest bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         collect <= '0;
      end else if (accept && !clear) begin
         for (int i = 0; i < S; i++) begin
            if (cnt == CW'(i)) begin
               collect[5*i +: 5] <= sample;
            end
         end
      end
   end

   // Output register: takes a full group when empty or being popped, so valid
   // stays high across a pop-and-refill edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sCol      <= '0;
         sColValid <= 1'b0;
      end else if (clear) begin
         sColValid <= 1'b0;
      end else if (transfer) begin
         sCol      <= collect;
         sColValid <= 1'b1;
      end else if (pop) begin
         sColValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_frodo_sampler.sv
`timescale 1ns/1ps
// Self-checking bench for frodo_sampler: three instances (one per table)
// share the same stimulus and are compared every cycle against a queue model.
module tb_frodo_sampler;

   localparam int S = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           clear = 1'b0;
   logic [15:0]    rnd = 16'd0;
   logic           rndValid = 1'b0;
   logic           sColReady = 1'b0;
   logic           rdy [3];
   logic           vld [3];
   logic [5*S-1:0] col [3];

   int errors = 0;
   int checks = 0;

   frodo_sampler #(.S(S), .PSET(0)) u0 (
      .clk(clk), .rst(rst), .clear(clear), .rnd(rnd), .rndValid(rndValid),
      .rndReady(rdy[0]), .sCol(col[0]), .sColValid(vld[0]), .sColReady(sColReady));
   frodo_sampler #(.S(S), .PSET(1)) u1 (
      .clk(clk), .rst(rst), .clear(clear), .rnd(rnd), .rndValid(rndValid),
      .rndReady(rdy[1]), .sCol(col[1]), .sColValid(vld[1]), .sColReady(sColReady));
   frodo_sampler #(.S(S), .PSET(2)) u2 (
      .clk(clk), .rst(rst), .clear(clear), .rnd(rnd), .rndValid(rndValid),
      .rndReady(rdy[2]), .sCol(col[2]), .sColValid(vld[2]), .sColReady(sColReady));

   always #5 clk = ~clk;

   int tab0 [13] = '{4643, 13363, 20579, 25843, 29227, 31145, 32103, 32525,
                     32689, 32745, 32762, 32766, 32767};
   int tab1 [11] = '{5638, 15915, 23689, 28571, 31116, 32217, 32613, 32731,
                     32760, 32766, 32767};
   int tab2 [7]  = '{9142, 23462, 30338, 32361, 32725, 32765, 32767};

   // Reference mapping straight from the table definition.
   function automatic logic [4:0] refSample(input logic [15:0] w, input int p);
      int tv;
      int m;
      tv = int'(w[15:1]);
      m = 0;
      if (p == 0) begin
         for (int j = 0; j < 12; j++) if (tab0[j] < tv) m++;
      end else if (p == 1) begin
         for (int j = 0; j < 10; j++) if (tab1[j] < tv) m++;
      end else begin
         for (int j = 0; j < 6; j++) if (tab2[j] < tv) m++;
      end
      return {m[3:0], w[0]};
   endfunction

   // Model state: words waiting in the group, words of the visible group.
   logic [15:0] pend [$];
   logic [15:0] outw [S];
   bit          outv = 1'b0;

   initial foreach (outw[i]) outw[i] = 16'd0;

   function automatic logic [5*S-1:0] refCol(input int p);
      logic [5*S-1:0] c;
      c = '0;
      for (int i = 0; i < S; i++) c[5*i +: 5] = refSample(outw[i], p);
      return c;
   endfunction

   // Model update: a group moves out only when complete and the output is free.
   always @(posedge clk or negedge rst) begin : model
      bit canTake;
      if (!rst) begin
         pend.delete();
         outv = 1'b0;
         foreach (outw[i]) outw[i] = 16'd0;
      end else begin
         canTake = (pend.size() < S);
         if (clear) begin
            pend.delete();
            outv = 1'b0;
         end else if (pend.size() == S && (!outv || sColReady)) begin
            for (int i = 0; i < S; i++) outw[i] = pend[i];
            pend.delete();
            outv = 1'b1;
         end else begin
            if (outv && sColReady) outv = 1'b0;
            if (rndValid && canTake) pend.push_back(rnd);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of all three instances against the model.
   always @(negedge clk) begin
      for (int p = 0; p < 3; p++) begin
         checkOutput($sformatf("rndReady[p%0d]", p), 64'(rdy[p]), 64'(pend.size() < S));
         checkOutput($sformatf("sColValid[p%0d]", p), 64'(vld[p]), 64'(outv));
         checkOutput($sformatf("sCol[p%0d]", p), 64'(col[p]), 64'(refCol(p)));
      end
   end

   logic [15:0] stim [$];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Presents stim words in order; a word is consumed when rndReady was high.
   task automatic applyStimulus(input int budget, output int accepted);
      int cyc;
      logic willTake;
      accepted = 0;
      cyc = 0;
      while (accepted < stim.size() && cyc < budget) begin
         rnd = stim[accepted];
         rndValid = 1'b1;
         willTake = rdy[0];
         tick();
         cyc++;
         if (willTake) accepted++;
      end
      rndValid = 1'b0;
   endtask

   logic [4:0] exp0 [8] = '{5'h00, 5'h00, 5'h02, 5'h03, 5'h19, 5'h02, 5'h02, 5'h01};
   logic [4:0] exp1 [8] = '{5'h00, 5'h00, 5'h00, 5'h01, 5'h15, 5'h02, 5'h02, 5'h01};
   logic [4:0] exp2 [8] = '{5'h00, 5'h00, 5'h00, 5'h01, 5'h0D, 5'h00, 5'h02, 5'h01};
   logic [15:0] magWords [8] = '{16'h2448, 16'h6868, 16'hA0C8, 16'hC9E8,
                                 16'hE458, 16'hF354, 16'hFAD0, 16'hFE1C};

   initial begin
      int acc;
      logic [5*S-1:0] snap;

      // Reset and idle
      tick();
      tick();
      checkOutput("reset rndReady", 64'(rdy[0]), 64'd1);
      checkOutput("reset sColValid", 64'(vld[0]), 64'd0);
      checkOutput("reset sCol", 64'(col[0]), 64'd0);
      rst = 1'b1;
      tick();

      // CDF boundary words across all three tables
      sColReady = 1'b1;
      stim = '{16'h0000, 16'h2446, 16'h2448, 16'h2449, 16'hFFFF, 16'h4756, 16'h476E, 16'h0001};
      applyStimulus(20, acc);
      checkOutput("map accepted", 64'(acc), 64'd8);
      tick();
      checkOutput("map sColValid", 64'(vld[0]), 64'd1);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("map p0 slot%0d", i), 64'(col[0][5*i +: 5]), 64'(exp0[i]));
         checkOutput($sformatf("map p1 slot%0d", i), 64'(col[1][5*i +: 5]), 64'(exp1[i]));
         checkOutput($sformatf("map p2 slot%0d", i), 64'(col[2][5*i +: 5]), 64'(exp2[i]));
      end
      tick();

      // Packing and latency
      stim.delete();
      foreach (magWords[i]) stim.push_back(magWords[i]);
      applyStimulus(20, acc);
      checkOutput("pack accepted", 64'(acc), 64'd8);
      checkOutput("pack bubble rndReady", 64'(rdy[0]), 64'd0);
      checkOutput("pack early sColValid", 64'(vld[0]), 64'd0);
      tick();
      checkOutput("pack sColValid", 64'(vld[0]), 64'd1);
      checkOutput("pack rndReady back", 64'(rdy[0]), 64'd1);
      checkOutput("pack slot0", 64'(col[0][4:0]), 64'h02);
      checkOutput("pack slot7", 64'(col[0][39:35]), 64'h10);
      tick();
      tick();

      // Back-pressure
      sColReady = 1'b0;
      stim.delete();
      for (int i = 0; i < 20; i++) stim.push_back(16'(i * 16'h1357 + 16'h0101));
      applyStimulus(30, acc);
      checkOutput("bp accepted", 64'(acc), 64'd16);
      checkOutput("bp rndReady", 64'(rdy[0]), 64'd0);
      checkOutput("bp sColValid", 64'(vld[0]), 64'd1);
      snap = col[0];
      tick();
      checkOutput("bp sCol stable", 64'(col[0]), 64'(snap));
      sColReady = 1'b1;
      tick();
      sColReady = 1'b0;
      checkOutput("bp swap sColValid", 64'(vld[0]), 64'd1);
      checkOutput("bp swap rndReady", 64'(rdy[0]), 64'd1);
      checkOutput("bp group2 slot0", 64'(col[0][4:0]), 64'(refSample(16'(8 * 16'h1357 + 16'h0101), 0)));

      // Clear with a partial group, a full output and a word on offer
      stim.delete();
      for (int i = 0; i < 5; i++) stim.push_back(16'hFFFF);
      applyStimulus(10, acc);
      checkOutput("clr pre accepted", 64'(acc), 64'd5);
      checkOutput("clr pre sColValid", 64'(vld[0]), 64'd1);
      clear = 1'b1;
      rnd = 16'hABCD;
      rndValid = 1'b1;
      tick();
      clear = 1'b0;
      rndValid = 1'b0;
      checkOutput("clr sColValid", 64'(vld[0]), 64'd0);
      checkOutput("clr rndReady", 64'(rdy[0]), 64'd1);
      sColReady = 1'b1;
      stim.delete();
      for (int i = 7; i >= 0; i--) stim.push_back(magWords[i]);
      applyStimulus(20, acc);
      tick();
      checkOutput("clr post sColValid", 64'(vld[0]), 64'd1);
      checkOutput("clr post slot0", 64'(col[0][4:0]), 64'h10);
      checkOutput("clr post slot7", 64'(col[0][39:35]), 64'h02);
      tick();

      // Reset mid-stream
      stim.delete();
      for (int i = 0; i < 3; i++) stim.push_back(16'hFFFF);
      applyStimulus(10, acc);
      #1 rst = 1'b0;
      #1;
      for (int p = 0; p < 3; p++) begin
         checkOutput($sformatf("midrst rndReady[p%0d]", p), 64'(rdy[p]), 64'd1);
         checkOutput($sformatf("midrst sColValid[p%0d]", p), 64'(vld[p]), 64'd0);
         checkOutput($sformatf("midrst sCol[p%0d]", p), 64'(col[p]), 64'd0);
      end
      tick();
      rst = 1'b1;
      stim.delete();
      foreach (magWords[i]) stim.push_back(magWords[i]);
      applyStimulus(20, acc);
      checkOutput("postrst early sColValid", 64'(vld[0]), 64'd0);
      tick();
      checkOutput("postrst sColValid", 64'(vld[0]), 64'd1);
      checkOutput("postrst slot0", 64'(col[0][4:0]), 64'h02);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frodo_sampler.md
# frodo_sampler

Error-sample generator feeding the FrodoKEM matrix multiplier's secret operand. Consumes a stream of 16-bit random words, maps each through the FrodoKEM CDF inversion table to one 5-bit sign-magnitude sample, and packs S consecutive samples into one column word that drives the multiplier's `sCol`/`sMat` rows directly. A two-level buffer (collect register plus output register) with valid/ready handshakes on both sides decouples the random source from the multiplier sequencer.

## Interface
- `S`, default 8: samples per output group; must match the multiplier's `S`.
- `PSET`, default 0: CDF table select. 0 = FrodoKEM-640, 1 = -976, 2 = -1344. Any other value is illegal.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `clear` input 1: synchronous flush of collect and output buffers.
- `rnd` input 16: random word.
- `rndValid` input 1: `rnd` is valid.
- `rndReady` output 1: block accepts `rnd` this cycle.
- `sCol` output 5*S: sample n at `sCol[5n+:5]`; bit 0 = sign (1 = negative), bits 4:1 = magnitude.
- `sColValid` output 1: `sCol` holds a complete group.
- `sColReady` input 1: consumer takes the group this cycle.

## Operation
- Per-word mapping (combinational, constant-time, all table entries always compared):
  - `t = rnd[15:1]` (15 bits).
  - `mag` = count of entries T[j], j = 0..L-2, with T[j] < t (unsigned compare).
  - `sign = rnd[0]`. Output sample = {mag[3:0], sign}. A sample with mag 0 and sign 1 is legal and is passed through unchanged; the multiplier negates it to 0.
- Tables (T[0..L-1]):
  - PSET 0, L=13: 4643 13363 20579 25843 29227 31145 32103 32525 32689 32745 32762 32766 32767. Max mag 12.
  - PSET 1, L=11: 5638 15915 23689 28571 31116 32217 32613 32731 32760 32766 32767. Max mag 10.
  - PSET 2, L=7: 9142 23462 30338 32361 32725 32765 32767. Max mag 6.
- Collect register: S slots, counter `cnt` 0..S.
  - Accept = `rndValid & rndReady`. On accept, the sample is written to slot `cnt` and `cnt` increments.
  - The first accepted word of a group lands in slot 0, the lowest bits.
- `rndReady = (cnt != S)`. The signal is combinational from state only and does not depend on `rndValid`.
- Transfer: when `cnt == S` and (`!sColValid | sColReady`), the collect register is copied to `sCol`, `sColValid` is set, and `cnt` returns to 0. No accept can occur in that cycle.
- Output handshake: a pop occurs when `sColValid & sColReady`. If no transfer happens in the same cycle, `sColValid` clears. `sCol` is stable while `sColValid & !sColReady`.
- `clear`: at the next edge, `cnt` becomes 0 and `sColValid` becomes 0. Any accept or transfer in that cycle is discarded. `clear` has priority over all other updates.

## Timing
- Reset values: `cnt`=0, collect slots=0, `sCol`=0, `sColValid`=0. Hence `rndReady`=1 during and after reset.
- Reset asserted mid-group drops the partial group and the output group with no residue. The first group after reset release contains only post-reset words.
- Latency: last word of a group accepted at edge k gives `cnt`=S after edge k. With the output free, `sColValid`=1 after edge k+1.
- Throughput: S words per S+1 cycles, one bubble per group. `rndReady` is low for exactly 1 cycle per group when the output is free.
- Back-pressure: if the output is held full, `cnt` stays at S and `rndReady` stays 0 until the pop edge. The transfer happens on that same pop edge, so `sColValid` stays high across the swap with new data.
- `rndValid` low: `cnt` holds and nothing changes.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst`=0 mid-stream, then release.
  - Required: `sColValid`=0, `sCol`=0 and `rndReady`=1 while reset is asserted. No output until S new words are accepted after release.
- CDF boundaries, PSET 0:
  - 0x0000 → 0x00.
  - 0x2446 (t=4643) → 0x00.
  - 0x2448 (t=4644) → 0x02.
  - 0x2449 → 0x03.
  - 0xFFFF (t=32767) → 0x19 (mag 12, negative).
- Tables for PSET 1 and 2:
  - 0xFFFF → 0x15 (PSET 1) and 0x0D (PSET 2).
  - 0x4756 (t=9131) → 0x00 (PSET 2).
  - 0x476E (t=9143) → 0x02 (PSET 2).
- Packing and latency, S=8:
  - Stimulus: feed words whose samples are 0x02 0x04 … 0x10 (mag 1..8) on consecutive cycles with `sColReady`=1.
  - Required: mag1 in `sCol[4:0]` and mag8 in `sCol[39:35]`. `sColValid` rises one edge after the 8th accept. `rndReady` is low for exactly 1 cycle.
- Back-pressure:
  - Stimulus: hold `sColReady`=0 while streaming 20 words.
  - Required: 16 words are accepted, then `rndReady`=0. `sCol` is stable (group 1).
  - Then: one cycle of `sColReady`=1 gives group 2 on `sCol` with `sColValid` still 1, and `rndReady` goes to 1.
- Clear:
  - Stimulus: assert `clear` with `cnt`=5 and `sColValid`=1, while also presenting `rndValid`=1.
  - Required: next cycle `cnt`=0, `sColValid`=0 and the word is not consumed. The next output group contains only post-clear words.
